// File: rtl/id_ex_fwd_stage_if.sv
// ID/EX stage bundle: ID operands and pipeline destinations in, EX operands,
// forwarding selects and load-use stall out. The slave side is the stage itself.
interface id_ex_fwd_stage_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [7:0]        id_ctrl;
  logic              flush;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_reg_write;
  logic [XLEN-1:0]   memwb_wdata;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm;
  logic [7:0]        ex_ctrl;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall_o;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_ctrl, flush, exmem_rd, exmem_reg_write, memwb_rd,
           memwb_reg_write, memwb_wdata,
    input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_ctrl, fwd_a, fwd_b, stall_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_ctrl, flush, exmem_rd, exmem_reg_write, memwb_rd,
           memwb_reg_write, memwb_wdata,
    output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_ctrl, fwd_a, fwd_b, stall_o
  );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with EX operand forwarding selects and load-use stall.
// Define HAZARD_STATS_EN to add saturating stall_count / flush_count outputs.
module id_ex_fwd_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_fwd_stage_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);
  localparam int MEM_READ = 1;

  logic              r_valid;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]   r_rs1_data, r_rs2_data, r_imm;
  logic [7:0]        r_ctrl;

  logic              w_stall, w_wt1, w_wt2;
  logic [1:0]        w_fwd_a, w_fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic              vld,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] xm_rd,
    input logic              xm_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (vld && xm_we && xm_rd != '0 && xm_rd == rs)      sel = 2'b10;
    else if (vld && wb_we && wb_rd != '0 && wb_rd == rs) sel = 2'b01;
    return sel;
  endfunction

  assign w_stall = bus.id_valid & r_valid & r_ctrl[MEM_READ] & (r_rd != '0) &
                   ((r_rd == bus.id_rs1) | (r_rd == bus.id_rs2)) & ~bus.flush;

  // Register file writes this same cycle, so the read data is stale on a match.
  assign w_wt1 = bus.memwb_reg_write & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.id_rs1);
  assign w_wt2 = bus.memwb_reg_write & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.id_rs2);

  assign w_fwd_a = fwd_sel(r_valid, r_rs1, bus.exmem_rd, bus.exmem_reg_write,
                           bus.memwb_rd, bus.memwb_reg_write);
  assign w_fwd_b = fwd_sel(r_valid, r_rs2, bus.exmem_rd, bus.exmem_reg_write,
                           bus.memwb_rd, bus.memwb_reg_write);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
    end else if (bus.flush || w_stall) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
    end else begin
      r_valid    <= bus.id_valid;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      r_rd       <= bus.id_rd;
      r_rs1_data <= w_wt1 ? bus.memwb_wdata : bus.id_rs1_data;
      r_rs2_data <= w_wt2 ? bus.memwb_wdata : bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_ctrl     <= bus.id_valid ? bus.id_ctrl : 8'h00;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush && r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`endif

  assign bus.ex_valid    = r_valid;
  assign bus.ex_rs1      = r_rs1;
  assign bus.ex_rs2      = r_rs2;
  assign bus.ex_rd       = r_rd;
  assign bus.ex_rs1_data = r_rs1_data;
  assign bus.ex_rs2_data = r_rs2_data;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_ctrl     = r_ctrl;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stall_o     = w_stall;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: forwarding table, hazard/reset sequences, and
// randomized traffic against a record-level model of the EX stage.
module tb_id_ex_fwd_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage_if #(.XLEN(64), .REG_AW(5)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
  id_ex_fwd_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall_count(stall_count), .flush_count(flush_count));
`else
  id_ex_fwd_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic [4:0] rs1, rs2, xm_rd;
    logic       xm_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic [1:0] ea, eb;
  } fvec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic [7:0]  ctrl;
  } ex_t;

  fvec_t vt[7];
  ex_t   m;
  logic [31:0] m_scnt, m_fcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_ctrl = 0;
    bus.flush = 0; bus.exmem_rd = 0; bus.exmem_reg_write = 0;
    bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_wdata = 0;
  endtask

  task automatic load_instr(input logic [4:0] rd);
    clr_in();
    bus.id_valid = 1; bus.id_ctrl = 8'h03; bus.id_rd = rd;
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2;
    tick();
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (!m.valid) return 2'b00;
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == rs) return 2'b10;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic e_stall;
    vt[0] = '{5'd5,  5'd6,  5'd5,  1'b1, 5'd5,  1'b1, 2'b10, 2'b00};
    vt[1] = '{5'd5,  5'd6,  5'd5,  1'b0, 5'd5,  1'b1, 2'b01, 2'b00};
    vt[2] = '{5'd1,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
    vt[3] = '{5'd4,  5'd4,  5'd4,  1'b1, 5'd9,  1'b1, 2'b10, 2'b10};
    vt[4] = '{5'd3,  5'd8,  5'd2,  1'b1, 5'd8,  1'b1, 2'b00, 2'b01};
    vt[5] = '{5'd7,  5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 2'b00, 2'b00};
    vt[6] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1, 2'b01, 2'b10};

    clr_in();
    tick(); tick();
    chk("rst ex_valid", bus.ex_valid, 0);
    chk("rst ex_ctrl", bus.ex_ctrl, 0);
    chk("rst fwd_a", bus.fwd_a, 0);
    chk("rst fwd_b", bus.fwd_b, 0);
    chk("rst stall", bus.stall_o, 0);
`ifdef HAZARD_STATS_EN
    chk("rst stall_count", stall_count, 0);
    chk("rst flush_count", flush_count, 0);
`endif
    reset = 0;
    tick();

    for (int i = 0; i < 7; i++) begin
      clr_in();
      bus.id_valid = 1; bus.id_rs1 = vt[i].rs1; bus.id_rs2 = vt[i].rs2;
      tick();
      bus.id_valid = 0;
      bus.exmem_rd = vt[i].xm_rd; bus.exmem_reg_write = vt[i].xm_we;
      bus.memwb_rd = vt[i].wb_rd; bus.memwb_reg_write = vt[i].wb_we;
      #1;
      chk($sformatf("vec%0d fwd_a", i), bus.fwd_a, vt[i].ea);
      chk($sformatf("vec%0d fwd_b", i), bus.fwd_b, vt[i].eb);
    end

    // Asynchronous reset in the middle of a stalled cycle.
    load_instr(5'd7);
    bus.id_valid = 1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7;
    bus.exmem_rd = 5'd1; bus.exmem_reg_write = 1;
    #1;
    chk("pre-rst stall", bus.stall_o, 1);
    chk("pre-rst fwd_a", bus.fwd_a, 2'b10);
    #1 reset = 1;
    #1;
    chk("mid-rst ex_valid", bus.ex_valid, 0);
    chk("mid-rst ex_ctrl", bus.ex_ctrl, 0);
    chk("mid-rst ex_rd", bus.ex_rd, 0);
    chk("mid-rst ex_rs1", bus.ex_rs1, 0);
    chk("mid-rst stall", bus.stall_o, 0);
    chk("mid-rst fwd_a", bus.fwd_a, 0);
    tick();
    reset = 0;

    // Load-use: exactly one bubble, then the held instruction enters EX.
    load_instr(5'd7);
    bus.id_valid = 1; bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd7; bus.id_rd = 5'd9;
    bus.id_ctrl = 8'h01;
    #1;
    chk("lu stall", bus.stall_o, 1);
    tick();
    chk("lu bubble valid", bus.ex_valid, 0);
    chk("lu bubble ctrl", bus.ex_ctrl, 0);
    chk("lu stall drop", bus.stall_o, 0);
    tick();
    chk("lu held valid", bus.ex_valid, 1);
    chk("lu held rs2", bus.ex_rs2, 7);
    chk("lu held rd", bus.ex_rd, 9);
    chk("lu held ctrl", bus.ex_ctrl, 8'h01);

    // Flush wins over a simultaneous load-use hazard.
    reset = 1; tick(); reset = 0;
    load_instr(5'd7);
    bus.id_valid = 1; bus.id_rs1 = 5'd7; bus.id_ctrl = 8'h01; bus.flush = 1;
    #1;
    chk("fl stall", bus.stall_o, 0);
    tick();
    chk("fl ex_valid", bus.ex_valid, 0);
    chk("fl ex_ctrl", bus.ex_ctrl, 0);
`ifdef HAZARD_STATS_EN
    chk("fl flush_count", flush_count, 1);
    chk("fl stall_count", stall_count, 0);
`endif

    // Write-through of the same-cycle register-file write.
    clr_in();
    bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1;
    bus.memwb_wdata = 64'hDEAD_BEEF_0000_0001;
    bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 0;
    bus.id_rs2 = 5'd4; bus.id_rs2_data = 64'h1234;
    tick();
    chk("wt rs1_data", bus.ex_rs1_data, 64'hDEAD_BEEF_0000_0001);
    chk("wt rs2_data", bus.ex_rs2_data, 64'h1234);

    // Randomized traffic against the EX record model.
    clr_in();
    reset = 1; tick(); reset = 0;
    m = '{default: '0};
    m_scnt = 0; m_fcnt = 0;
    for (int c = 0; c < 400; c++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_rs1 = 5'($urandom_range(0, 7));
      bus.id_rs2 = 5'($urandom_range(0, 7));
      bus.id_rd  = 5'($urandom_range(0, 7));
      bus.id_rs1_data = {$urandom, $urandom};
      bus.id_rs2_data = {$urandom, $urandom};
      bus.id_imm = {$urandom, $urandom};
      bus.id_ctrl = 8'($urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.exmem_rd = 5'($urandom_range(0, 7));
      bus.exmem_reg_write = 1'($urandom);
      bus.memwb_rd = 5'($urandom_range(0, 7));
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_wdata = {$urandom, $urandom};
      #1;
      e_stall = bus.id_valid && m.valid && m.ctrl[1] && m.rd != 0 &&
                (m.rd == bus.id_rs1 || m.rd == bus.id_rs2) && !bus.flush;
      chk("rnd ex_valid", bus.ex_valid, m.valid);
      chk("rnd ex_rs1", bus.ex_rs1, m.rs1);
      chk("rnd ex_rs2", bus.ex_rs2, m.rs2);
      chk("rnd ex_rd", bus.ex_rd, m.rd);
      chk("rnd ex_rs1_data", bus.ex_rs1_data, m.d1);
      chk("rnd ex_rs2_data", bus.ex_rs2_data, m.d2);
      chk("rnd ex_imm", bus.ex_imm, m.imm);
      chk("rnd ex_ctrl", bus.ex_ctrl, m.ctrl);
      chk("rnd stall", bus.stall_o, e_stall);
      chk("rnd fwd_a", bus.fwd_a, exp_fwd(m.rs1));
      chk("rnd fwd_b", bus.fwd_b, exp_fwd(m.rs2));
`ifdef HAZARD_STATS_EN
      chk("rnd stall_count", stall_count, m_scnt);
      chk("rnd flush_count", flush_count, m_fcnt);
`endif
      @(posedge clk);
      if (e_stall) m_scnt++;
      if (bus.flush) m_fcnt++;
      if (bus.flush || e_stall) begin
        m = '{default: '0};
      end else begin
        m.valid = bus.id_valid;
        m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
        m.d1 = (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == bus.id_rs1)
               ? bus.memwb_wdata : bus.id_rs1_data;
        m.d2 = (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == bus.id_rs2)
               ? bus.memwb_wdata : bus.id_rs2_data;
        m.imm = bus.id_imm;
        m.ctrl = bus.id_valid ? bus.id_ctrl : 8'h00;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
